pkt_stats_cpu_regs: RTL
=======================

PKT_STATS_CPU_REGS -- requirements
Module: pkt_stats_cpu_regs

Interface
REQ-001 The block SHALL have parameter C_BASE_ADDRESS, 32'h00000000, AXI-Lite base address, XORed with the incoming address.
REQ-002 The block SHALL have parameter C_NUM_CNT, 4, number of event counters, legal range 1..16.
REQ-003 The block SHALL have parameter C_CNT_WIDTH, 48, counter width, legal range 33..64.
REQ-004 The block SHALL have parameter C_ID, 32'h0000DA01, value returned by the ID register.
REQ-005 The block SHALL have port clk, input, 1, single clock for the AXI-Lite slave and the counters.
REQ-006 The block SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-007 The block SHALL have port cnt_inc, input, C_NUM_CNT, one bit per counter; a bit high on a clk edge counts one event.
REQ-008 The block SHALL have port enable_reg, output, 32, software enable register.
REQ-009 The block SHALL have port soft_rst_pulse, output, 1, one-cycle pulse produced by a write to RESET.
REQ-010 The block SHALL have the standard AXI-Lite slave ports S_AXI_AW*/W*/B*/AR*/R*, 32-bit address and 32-bit data, WSTRB 4 bits, BRESP and RRESP 2 bits.

Function
REQ-011 Address map (offset = addr ^ C_BASE_ADDRESS):
- 0x00 ID, RO
- 0x04 VERSION, RO, 32'h00020000
- 0x08 RESET, WO
- 0x0C ENABLE, RW
- 0x10 CTRL, RW; bit0 clear-on-read (cor), bit1 freeze
- 0x40+8*i counter i low word, RO
- 0x44+8*i counter i high word, RO; bits above C_CNT_WIDTH-32 read as zero
REQ-012 Write channel SHALL be an FSM W_IDLE -> W_RESP:
- in W_IDLE, when AWVALID and WVALID are both high, AWREADY and WREADY SHALL pulse together for one cycle and the write SHALL commit;
- W_RESP SHALL hold BVALID until BREADY and then return to W_IDLE;
- AW or W arriving alone SHALL wait and SHALL NOT be accepted.
REQ-013 Write commit SHALL apply WSTRB per byte to ENABLE and CTRL.
REQ-014 A RESET write with any strobe set SHALL drive soft_rst_pulse high for exactly one cycle after commit.
REQ-015 Read channel SHALL be an FSM R_IDLE -> R_DATA:
- ARREADY SHALL pulse for one cycle in R_IDLE when ARVALID is high;
- RVALID and RDATA SHALL be registered on the following cycle (latency 1) and held until RREADY;
- a new AR SHALL NOT be accepted while RVALID is high.
REQ-016 Unmapped read SHALL return 32'hDEADBEEF with RRESP=2'b10 (SLVERR); unmapped or RO-target write SHALL have no effect and BRESP=2'b10; all other responses SHALL be 2'b00.
REQ-017 Each counter SHALL increment by 1 per cycle with cnt_inc[i] high, unless CTRL.freeze=1.
REQ-018 Reading a low word SHALL return the live low 32 bits and, in the same cycle, latch counter bits [C_CNT_WIDTH-1:32] into a per-counter snapshot; the high-word read SHALL return that snapshot.
REQ-019 If CTRL.cor=1, a low-word read SHALL clear the counter on the AR accept cycle; a simultaneous increment SHALL leave the counter at 1; the returned data SHALL be the pre-clear value.
REQ-020 Counter overflow SHALL follow REQ-027.

Reset
REQ-021 While resetn=0, the block SHALL drive all of AWREADY, WREADY, BVALID, ARREADY, RVALID, soft_rst_pulse low, RDATA=0, BRESP=RRESP=0.
REQ-022 While resetn=0, the block SHALL set ENABLE=0, CTRL=0, all counters and snapshots =0, and both FSMs to idle.
REQ-023 Reset asserted mid-transaction SHALL abort it; no response SHALL be issued for it after reset release.
REQ-024 Reset SHALL NOT be affected by soft_rst_pulse; that output is informational only for downstream logic.

Configuration
REQ-025 The block SHALL support the macro PKT_STATS_CNT_SATURATE_EN.
REQ-026 With PKT_STATS_CNT_SATURATE_EN defined, a counter at all-ones SHALL hold all-ones on further increments.
REQ-027 Without PKT_STATS_CNT_SATURATE_EN, a counter SHALL wrap from all-ones to 0.

Verification
REQ-028 Register access: write 0x0C=32'h12345678 with WSTRB=4'b0011, then read 0x0C -> 32'h00005678, BRESP=RRESP=OKAY; read 0x00 -> C_ID.
REQ-029 Handshake ordering: AWVALID asserted 3 cycles before WVALID -> no AWREADY until WVALID is high, then a single BVALID; BREADY held low 5 cycles -> BVALID stays high throughout.
REQ-030 Snapshot: C_CNT_WIDTH=48, preload counter 0 to 48'h0001_FFFFFFFF, pulse cnt_inc[0] between the low and high reads -> low=32'hFFFFFFFF, high=32'h00000001.
REQ-031 Clear-on-read: cor=1, counter 2=10, cnt_inc[2] high on the AR accept cycle -> read returns 10, counter is 1 afterwards.
REQ-032 Boundary and errors: counter at all-ones plus one increment -> 0 without the macro, all-ones with it; read 0x3C -> 32'hDEADBEEF with SLVERR; resetn pulsed while BVALID is high -> BVALID low, no further response.

Source files
------------

// File: rtl/pkt_stats_cpu_regs.sv
// -----------------------------------------------------------------------------
// pkt_stats_cpu_regs
//
// AXI-Lite register block for packet statistics: ID/VERSION, a software
// reset pulse, an enable register, a control register (clear-on-read and
// freeze), and C_NUM_CNT event counters of C_CNT_WIDTH bits. Each counter
// is read as a live low word plus a high word taken from a snapshot that is
// captured when the low word is read, so a low/high pair is coherent.
//
// Ports
//   clk, resetn         single clock, synchronous active-low reset
//   cnt_inc             one increment request per counter per clock
//   enable_reg          software ENABLE register contents
//   soft_rst_pulse      one-cycle pulse after a RESET register write
//   S_AXI_AW*/W*/B*     AXI-Lite write channels (32-bit addr/data)
//   S_AXI_AR*/R*        AXI-Lite read channels
//
// Build option
//   PKT_STATS_CNT_SATURATE_EN  counters stick at all-ones instead of wrapping
// -----------------------------------------------------------------------------
module pkt_stats_cpu_regs #(
    parameter logic [31:0] C_BASE_ADDRESS = 32'h0000_0000,
    parameter int          C_NUM_CNT      = 4,
    parameter int          C_CNT_WIDTH    = 48,
    parameter logic [31:0] C_ID           = 32'h0000_DA01
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [C_NUM_CNT-1:0] cnt_inc,
    output logic [31:0]          enable_reg,
    output logic                 soft_rst_pulse,
    input  logic [31:0]          S_AXI_AWADDR,
    input  logic                 S_AXI_AWVALID,
    output logic                 S_AXI_AWREADY,
    input  logic [31:0]          S_AXI_WDATA,
    input  logic [3:0]           S_AXI_WSTRB,
    input  logic                 S_AXI_WVALID,
    output logic                 S_AXI_WREADY,
    output logic [1:0]           S_AXI_BRESP,
    output logic                 S_AXI_BVALID,
    input  logic                 S_AXI_BREADY,
    input  logic [31:0]          S_AXI_ARADDR,
    input  logic                 S_AXI_ARVALID,
    output logic                 S_AXI_ARREADY,
    output logic [31:0]          S_AXI_RDATA,
    output logic [1:0]           S_AXI_RRESP,
    output logic                 S_AXI_RVALID,
    input  logic                 S_AXI_RREADY
);

    localparam int          HI_W        = C_CNT_WIDTH - 32;
    localparam logic [31:0] VERSION     = 32'h0002_0000;
    localparam logic [31:0] CNT_BASE    = 32'h0000_0040;
    localparam logic [31:0] CNT_SPAN    = 32'(8 * C_NUM_CNT);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_state_nxt;
    r_state_t r_state, r_state_nxt;
    logic     wr_hs, ar_hs;

    logic [31:0] enable_q;
    logic [1:0]  ctrl_q;          // [0] clear-on-read, [1] freeze
    logic        soft_rst_q;
    logic [1:0]  bresp_q, rresp_q;
    logic [31:0] rdata_q;

    logic [C_NUM_CNT-1:0][C_CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic [C_NUM_CNT-1:0][HI_W-1:0]        snap;
    logic [C_NUM_CNT-1:0]                  inc_ok;
    logic [C_NUM_CNT-1:0]                  lo_rd;

    logic [31:0] wr_off;
    logic        wr_err;
    logic [31:0] rd_off, rd_rel;
    logic        rd_cnt_hit, rd_hi, rd_err;
    logic [3:0]  rd_idx;
    logic [31:0] rd_data;

    function automatic logic [31:0] apply_strb(input logic [31:0] old,
                                               input logic [31:0] data,
                                               input logic [3:0]  strb);
        apply_strb = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) apply_strb[8*b +: 8] = data[8*b +: 8];
    endfunction

    function automatic logic [C_CNT_WIDTH-1:0] cnt_step(input logic [C_CNT_WIDTH-1:0] v);
`ifdef PKT_STATS_CNT_SATURATE_EN
        cnt_step = (&v) ? v : v + C_CNT_WIDTH'(1);
`else
        cnt_step = v + C_CNT_WIDTH'(1);
`endif
    endfunction

    // ---- channel state machines ----
    always_ff @(posedge clk) begin
        if (!resetn) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_nxt;
            r_state <= r_state_nxt;
        end
    end

    // AW and W are only taken together; either one alone just waits.
    always_comb begin
        w_state_nxt   = w_state;
        wr_hs         = 1'b0;
        case (w_state)
            W_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID) begin
                wr_hs       = 1'b1;
                w_state_nxt = W_RESP;
            end
            W_RESP: if (S_AXI_BREADY) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
        S_AXI_AWREADY = wr_hs && resetn;
        S_AXI_WREADY  = wr_hs && resetn;
    end

    always_comb begin
        r_state_nxt   = r_state;
        ar_hs         = 1'b0;
        case (r_state)
            R_IDLE: if (S_AXI_ARVALID) begin
                ar_hs       = 1'b1;
                r_state_nxt = R_DATA;
            end
            R_DATA: if (S_AXI_RREADY) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
        S_AXI_ARREADY = ar_hs && resetn;
    end

    // Outputs are gated by resetn so they read as idle during the reset cycle
    // itself, before the synchronous reset has reached the registers.
    assign S_AXI_BVALID   = resetn && (w_state == W_RESP);
    assign S_AXI_BRESP    = resetn ? bresp_q : 2'b00;
    assign S_AXI_RVALID   = resetn && (r_state == R_DATA);
    assign S_AXI_RRESP    = resetn ? rresp_q : 2'b00;
    assign S_AXI_RDATA    = resetn ? rdata_q : 32'h0;
    assign soft_rst_pulse = resetn && soft_rst_q;
    assign enable_reg     = enable_q;

    // ---- address decode ----
    always_comb begin
        wr_off = S_AXI_AWADDR ^ C_BASE_ADDRESS;
        wr_err = 1'b1;
        case (wr_off)
            32'h08, 32'h0C, 32'h10: wr_err = 1'b0;
            default:                wr_err = 1'b1;
        endcase
    end

    always_comb begin
        rd_off     = S_AXI_ARADDR ^ C_BASE_ADDRESS;
        rd_rel     = rd_off - CNT_BASE;
        rd_cnt_hit = (rd_off >= CNT_BASE) && (rd_rel < CNT_SPAN) && (rd_off[1:0] == 2'b00);
        rd_idx     = rd_rel[6:3];
        rd_hi      = rd_rel[2];
        rd_data    = 32'hDEAD_BEEF;
        rd_err     = 1'b1;
        lo_rd      = '0;
        case (rd_off)
            32'h00: begin rd_data = C_ID;             rd_err = 1'b0; end
            32'h04: begin rd_data = VERSION;          rd_err = 1'b0; end
            32'h08: begin rd_data = 32'h0;            rd_err = 1'b0; end
            32'h0C: begin rd_data = enable_q;         rd_err = 1'b0; end
            32'h10: begin rd_data = {30'h0, ctrl_q};  rd_err = 1'b0; end
            default: begin
                if (rd_cnt_hit) begin
                    for (int i = 0; i < C_NUM_CNT; i++) begin
                        if (rd_idx == 4'(i)) begin
                            rd_err = 1'b0;
                            if (rd_hi) begin
                                rd_data = 32'(snap[i]);
                            end else begin
                                rd_data  = cnt[i][31:0];
                                lo_rd[i] = ar_hs;
                            end
                        end
                    end
                end
            end
        endcase
    end

    // ---- register file and response registers ----
    always_ff @(posedge clk) begin
        if (!resetn) begin
            enable_q   <= 32'h0;
            ctrl_q     <= 2'b00;
            soft_rst_q <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= 32'h0;
        end else begin
            soft_rst_q <= wr_hs && (wr_off == 32'h08) && (|S_AXI_WSTRB);
            if (wr_hs) begin
                bresp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
                if (wr_off == 32'h0C)
                    enable_q <= apply_strb(enable_q, S_AXI_WDATA, S_AXI_WSTRB);
                if (wr_off == 32'h10 && S_AXI_WSTRB[0])
                    ctrl_q <= S_AXI_WDATA[1:0];
            end
            if (ar_hs) begin
                rdata_q <= rd_data;
                rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // ---- counters ----
    assign inc_ok = cnt_inc & ~{C_NUM_CNT{ctrl_q[1]}};

    // Clear-on-read takes priority over the step, but an increment landing on
    // the same cycle is kept so no event is lost.
    always_comb begin
        cnt_nxt = cnt;
        for (int i = 0; i < C_NUM_CNT; i++) begin
            if (lo_rd[i] && ctrl_q[0])
                cnt_nxt[i] = inc_ok[i] ? C_CNT_WIDTH'(1) : '0;
            else if (inc_ok[i])
                cnt_nxt[i] = cnt_step(cnt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt  <= '0;
            snap <= '0;
        end else begin
            cnt <= cnt_nxt;
            for (int i = 0; i < C_NUM_CNT; i++)
                if (lo_rd[i]) snap[i] <= cnt[i][C_CNT_WIDTH-1:32];
        end
    end

endmodule
